// File: rtl/acc_capture_pkg.sv
// Shared types and constants for the acc_capture result-capture stage.
// The ACC_CAPTURE_TSTAMP_EN macro selects three words per record (X, Y, timestamp) instead of two.
package acc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FULL    = 2'd3
  } state_e;

  // Which word of the current record the write port handles this cycle.
  typedef enum logic [1:0] {
    PH_X  = 2'd0,
    PH_Y  = 2'd1,
    PH_TS = 2'd2
  } phase_e;

  localparam int TSW = 32;

`ifdef ACC_CAPTURE_TSTAMP_EN
  localparam int STRIDE = 3;
`else
  localparam int STRIDE = 2;
`endif

endpackage

// File: rtl/acc_capture_ram.sv
// Single-clock simple-dual-port RAM for acc_capture.
// Port A is write-only. Port B is a registered, read-first read port.
module acc_capture_ram #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // A read of the address being written returns the previous contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/acc_capture.sv
// Per-channel capture of meas2 X/Y integrals into a RAM, armed by stb_start and opened by trig.
// Define ACC_CAPTURE_TSTAMP_EN to also store a timestamp (cycles since the opening trig) per record.
module acc_capture
  import acc_capture_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          stb_start,
  input  logic          trig,
  input  logic          done,
  input  logic [DW-1:0] xacc,
  input  logic [DW-1:0] yacc,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   wr_count,
  output logic          full,
  output logic          armed,
  output logic [CW-1:0] drops
);

  localparam logic [AW:0] DEPTH_W  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] STRIDE_W = (AW+1)'(STRIDE);

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  logic [AW:0]   wr_count_q, wr_count_d;
  logic [CW-1:0] drops_q, drops_d;
  logic [DW-1:0] y_q, y_d;
  logic          we;
  logic [DW-1:0] wdata;
  logic          drop;
  logic          last_word;
  logic [AW:0]   free_words;

`ifdef ACC_CAPTURE_TSTAMP_EN
  logic [TSW-1:0] ts_q, ts_d;
  logic [TSW-1:0] ts_lat_q, ts_lat_d;

  // Loading 1 on the opening trig makes the count equal the cycles elapsed since that trig.
  always_comb begin
    ts_d = ts_q + 1'b1;
    if (!stb_start && state_q == ARMED && trig) ts_d = TSW'(1);
  end
`endif

  assign free_words = DEPTH_W - wr_count_d;

  // NOTE: every variable gets a default at the top so no path through the block infers a latch.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wr_count_d = wr_count_q;
    drops_d    = drops_q;
    y_d        = y_q;
    we         = 1'b0;
    wdata      = xacc;
    drop       = 1'b0;
    last_word  = 1'b0;
`ifdef ACC_CAPTURE_TSTAMP_EN
    ts_lat_d   = ts_lat_q;
`endif

    if (stb_start) begin
      state_d    = ARMED;
      phase_d    = PH_X;
      wr_count_d = '0;
      drops_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ARMED: if (trig) state_d = CAPTURE;
        CAPTURE: begin
          unique case (phase_q)
            PH_X: if (done) begin
              we         = 1'b1;
              wdata      = xacc;
              y_d        = yacc;
`ifdef ACC_CAPTURE_TSTAMP_EN
              ts_lat_d   = ts_q;
`endif
              phase_d    = PH_Y;
              wr_count_d = wr_count_q + 1'b1;
            end
            PH_Y: begin
              we         = 1'b1;
              wdata      = y_q;
              drop       = done;
              wr_count_d = wr_count_q + 1'b1;
`ifdef ACC_CAPTURE_TSTAMP_EN
              phase_d    = PH_TS;
`else
              phase_d    = PH_X;
              last_word  = 1'b1;
`endif
            end
            default: begin
`ifdef ACC_CAPTURE_TSTAMP_EN
              we         = 1'b1;
              wdata      = DW'(ts_lat_q);
              drop       = done;
              wr_count_d = wr_count_q + 1'b1;
              last_word  = 1'b1;
`endif
              phase_d    = PH_X;
            end
          endcase
          if (last_word && free_words < STRIDE_W) state_d = FULL;
        end
        FULL: drop = done;
        default: state_d = IDLE;
      endcase
      if (drop && drops_q != {CW{1'b1}}) drops_d = drops_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phase_q    <= PH_X;
      wr_count_q <= '0;
      drops_q    <= '0;
      y_q        <= '0;
`ifdef ACC_CAPTURE_TSTAMP_EN
      ts_q       <= '0;
      ts_lat_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wr_count_q <= wr_count_d;
      drops_q    <= drops_d;
      y_q        <= y_d;
`ifdef ACC_CAPTURE_TSTAMP_EN
      ts_q       <= ts_d;
      ts_lat_q   <= ts_lat_d;
`endif
    end
  end

  acc_capture_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (reset_n),
    .we_i   (we),
    .waddr_i(wr_count_q[AW-1:0]),
    .wdata_i(wdata),
    .re_i   (rd_en),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  assign wr_count = wr_count_q;
  assign drops    = drops_q;
  assign full     = (state_q == FULL);
  assign armed    = (state_q == ARMED) || (state_q == CAPTURE);

endmodule

// File: tb/tb_acc_capture.sv
// Directed self-checking bench for acc_capture (AW=4, CW=4), covering both record strides.
module tb_acc_capture;
  import acc_capture_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 4;
  localparam int DEPTH  = 1 << AW;
  localparam int N_FILL = DEPTH / STRIDE;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          stb_start = 1'b0;
  logic          trig = 1'b0;
  logic          done = 1'b0;
  logic [DW-1:0] xacc = '0;
  logic [DW-1:0] yacc = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic [AW:0]   wr_count;
  logic          full;
  logic          armed;
  logic [CW-1:0] drops;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    int            exp_wr_count;
    logic          exp_full;
  } fill_vec_t;

  fill_vec_t fill_tab [8];

  acc_capture #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .stb_start(stb_start),
    .trig     (trig),
    .done     (done),
    .xacc     (xacc),
    .yacc     (yacc),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_count (wr_count),
    .full     (full),
    .armed    (armed),
    .drops    (drops)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    stb_start = 1'b1;
    tick();
    stb_start = 1'b0;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic pulse_done(input logic [DW-1:0] x, input logic [DW-1:0] y);
    done = 1'b1;
    xacc = x;
    yacc = y;
    tick();
    done = 1'b0;
  endtask

  task automatic read_word(input int addr, input logic [DW-1:0] exp, input string name);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    tick();
    rd_en = 1'b0;
    check(name, rd_data, exp);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      fill_tab[i].x            = 32'hA0A0_0000 + 32'(i);
      fill_tab[i].y            = 32'hB0B0_0000 + 32'(i);
      fill_tab[i].exp_wr_count = (i + 1) * STRIDE;
      fill_tab[i].exp_full     = (i == N_FILL - 1);
    end

    repeat (2) tick();
    check("reset_wr_count", wr_count, 0);
    check("reset_full", full, 0);
    check("reset_armed", armed, 0);
    check("reset_drops", drops, 0);
    check("reset_rd_data", rd_data, 0);
    reset_n = 1'b1;
    tick();

    // Arm and run
    pulse_start();
    check("arm_armed", armed, 1);
    pulse_trig();
    pulse_done(32'h1111_1111, 32'h2222_2222);
    repeat (STRIDE - 1) tick();
    check("run_wr_count", wr_count, STRIDE);
    read_word(0, 32'h1111_1111, "run_rd_x");
    rd_addr = AW'(1);
    tick();
    check("run_rd_hold", rd_data, 32'h1111_1111);
    read_word(1, 32'h2222_2222, "run_rd_y");

    // Pre-trigger gating, done in trig cycle ignored, read-first collision
    pulse_start();
    pulse_done(32'hDEAD_0001, 32'hDEAD_0002);
    tick();
    check("pretrig_wr_count", wr_count, 0);
    check("pretrig_drops", drops, 0);
    done = 1'b1;
    xacc = 32'hDEAD_0003;
    pulse_trig();
    done = 1'b0;
    tick();
    check("trigcycle_wr_count", wr_count, 0);
    rd_en   = 1'b1;
    rd_addr = '0;
    pulse_done(32'h3333_3333, 32'h4444_4444);
    rd_en = 1'b0;
    check("read_first_old", rd_data, 32'h1111_1111);
    repeat (STRIDE) tick();
    read_word(0, 32'h3333_3333, "pretrig_rd_x");
    read_word(1, 32'h4444_4444, "pretrig_rd_y");

    // Back-to-back done: the second lands in the Y-write cycle and is dropped
    pulse_start();
    pulse_trig();
    done = 1'b1;
    xacc = 32'h5555_5555;
    yacc = 32'h6666_6666;
    tick();
    xacc = 32'h7777_7777;
    yacc = 32'h8888_8888;
    tick();
    done = 1'b0;
    repeat (3) tick();
    check("b2b_wr_count", wr_count, STRIDE);
    check("b2b_drops", drops, 1);
    read_word(1, 32'h6666_6666, "b2b_rd_y");

    // Fill the RAM from the vector table
    pulse_start();
    pulse_trig();
    for (int i = 0; i < N_FILL; i++) begin
      pulse_done(fill_tab[i].x, fill_tab[i].y);
      repeat (STRIDE - 1) tick();
      check($sformatf("fill%0d_wr_count", i), wr_count, fill_tab[i].exp_wr_count);
      check($sformatf("fill%0d_full", i), full, fill_tab[i].exp_full);
      tick();
    end
    check("fill_armed", armed, 0);
    pulse_done(32'hFFFF_0000, 32'hFFFF_0001);
    check("overflow_drops", drops, 1);
    check("overflow_wr_count", wr_count, N_FILL * STRIDE);
    for (int i = 0; i < N_FILL; i++) begin
      read_word(i * STRIDE, fill_tab[i].x, $sformatf("fill%0d_rd_x", i));
      read_word(i * STRIDE + 1, fill_tab[i].y, $sformatf("fill%0d_rd_y", i));
    end
    done = 1'b1;
    repeat (20) tick();
    done = 1'b0;
    check("drops_saturate", drops, 15);

    // Restart with a coincident done, which must not count
    done = 1'b1;
    pulse_start();
    done = 1'b0;
    check("restart_full", full, 0);
    check("restart_drops", drops, 0);
    check("restart_wr_count", wr_count, 0);
    check("restart_armed", armed, 1);

    // Async reset during the X-write cycle
    pulse_trig();
    done = 1'b1;
    xacc = 32'hBAD0_BAD0;
    yacc = 32'hBAD1_BAD1;
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_armed", armed, 0);
    check("areset_wr_count", wr_count, 0);
    check("areset_rd_data", rd_data, 0);
    check("areset_full", full, 0);
    done = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
    pulse_trig();
    pulse_done(32'hBAD2_BAD2, 32'hBAD3_BAD3);
    repeat (STRIDE) tick();
    check("areset_idle_wr_count", wr_count, 0);
    check("areset_idle_drops", drops, 0);
    read_word(0, fill_tab[0].x, "areset_rd_x0");
    read_word(1, fill_tab[0].y, "areset_rd_y0");

`ifdef ACC_CAPTURE_TSTAMP_EN
    // Timestamp equals cycles elapsed since the trig cycle (no offset)
    pulse_start();
    pulse_trig();
    repeat (99) tick();
    pulse_done(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (3) tick();
    check("ts_wr_count", wr_count, 3);
    read_word(2, 32'd100, "ts_word");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
